ras_speculative: RTL and testbench
==================================

Name: ras_speculative

Overview:
- Parametrised return-address stack (RAS) with speculative checkpoint and rollback.
- Successor to the fixed-depth RAS inside the IF-stage branch predictor. Three differences from that RAS:
  - depth, address width and checkpoint count are parameters;
  - the ad-hoc pop/push rollback flags are replaced by tagged checkpoints;
  - overflow wrap and underflow are defined explicitly.
- Sits in IF. The mini control drives push/pop from jal/jalr decode. The branch resolution logic drives rollback on PL_flush.

Parameters:
- DEPTH, 8, number of stack entries (power of 2, >=2).
- WIDTH, 32, return-address width in bits.
- NCKPT, 4, number of checkpoint slots (power of 2, >=2).
- Derived: PW = clog2(DEPTH), TW = clog2(NCKPT), CW = clog2(DEPTH+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  freezes push, pop and ckpt_save; rollback still acts.
- push  in  1  push push_addr (call).
- push_addr  in  WIDTH  return address to push (pc+4 of the call).
- pop  in  1  pop the top entry (return).
- top_addr  out  WIDTH  predicted return address, mem[tos], combinational.
- top_valid  out  1  count != 0.
- count  out  CW  number of valid entries, saturates at DEPTH.
- ckpt_save  in  1  snapshot the current state into slot ckpt_tag.
- ckpt_tag  out  TW  slot the next save will use; the tag travels with the instruction.
- rollback  in  1  restore the state saved in slot rollback_tag.
- rollback_tag  in  TW  slot to restore.

Behaviour:
- Reset (async, while rst=1):
  - all mem entries = 0;
  - tos = 0, count = 0, ckpt_tag = 0, all checkpoint slots = 0;
  - therefore top_addr = 0 and top_valid = 0.
- State: mem[DEPTH] circular buffer; tos pointer (PW bits); count.
- Operations, applied at the rising edge when stall = 0 and rollback = 0:
  - push only: tos <= tos+1 (mod DEPTH); mem[tos+1] <= push_addr; count <= min(count+1, DEPTH).
  - Push at count = DEPTH wraps onto the oldest entry and overwrites it silently. count stays DEPTH.
  - pop only, count > 0: tos <= tos-1 (mod DEPTH); count <= count-1.
  - pop only, count = 0 (underflow): no state change; top_valid stays 0.
  - push and pop together, count > 0: mem[tos] <= push_addr (replace top); tos and count unchanged.
  - push and pop together, count = 0: behaves as push only.
  - Neither push nor pop: hold.
- Checkpoint:
  - On ckpt_save with stall = 0: slot[ckpt_tag] <= {tos, count, mem[tos]}, using pre-update values from the same cycle; ckpt_tag <= ckpt_tag+1 (mod NCKPT).
  - A same-cycle push/pop still applies to the live state.
  - Slots are reused round-robin with no overflow detection. The pipeline guarantees at most NCKPT checkpoints are outstanding.
- Rollback:
  - On rollback: tos <= slot.tos, count <= slot.count, mem[slot.tos] <= slot.top; ckpt_tag <= rollback_tag+1 (mod NCKPT).
  - rollback has priority over push, pop and ckpt_save in the same cycle; all three are ignored.
  - rollback acts even when stall = 1.
- Accepted limitation: only the top entry is repaired. An entry below tos that was overwritten after the checkpoint (pop, pop, push) stays corrupted. This is a prediction-accuracy loss only, never a correctness loss.
- Latency: top_addr, top_valid and count reflect an update from the cycle after the edge. There is no read-through of a same-cycle push.
- Reset asserted mid-operation overrides everything immediately.

Test Plan (DEPTH=4, WIDTH=32, NCKPT=4):
- Reset, then push 0x100, 0x200, 0x300 -> top_addr=0x300, count=3; one pop -> top_addr=0x200, count=2.
- Overflow: push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 -> count=4.
  - Four pops -> top_addr before each pop reads 0xE0, 0xD0, 0xC0, 0xB0.
  - After the 4th pop -> top_valid=0, count=0.
- Underflow: from reset, pop for 3 cycles -> tos, count and top_addr unchanged (0), top_valid=0; a later push 0x40 -> top_addr=0x40, count=1.
- Replace: state {0x100, 0x200}, push+pop with push_addr 0x900 -> top_addr=0x900, count=2; pop -> top_addr=0x100.
- Checkpoint/rollback:
  - Push 0x100, 0x200; ckpt_save -> tag 0, ckpt_tag becomes 1.
  - Pop, then push 0x700 (overwrites the 0x200 slot) -> top_addr=0x700.
  - rollback with rollback_tag=0 -> top_addr=0x200, count=2, ckpt_tag=1; pop -> 0x100.
- Priority/stall:
  - rollback asserted together with push 0x555 and stall=1 -> rollback state restored, 0x555 not written.
  - stall=1 with push -> no change.
  - rst pulse mid-sequence -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/ras_speculative_if.sv
// Return-address stack port bundle: push/pop/checkpoint controls in, prediction and next tag out.
// The master drives the controls and rollback; the slave is the stack itself.
interface ras_speculative_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int NCKPT = 4
);
    localparam int TW = $clog2(NCKPT);
    localparam int CW = $clog2(DEPTH + 1);

    logic             stall;
    logic             push;
    logic [WIDTH-1:0] push_addr;
    logic             pop;
    logic [WIDTH-1:0] top_addr;
    logic             top_valid;
    logic [CW-1:0]    count;
    logic             ckpt_save;
    logic [TW-1:0]    ckpt_tag;
    logic             rollback;
    logic [TW-1:0]    rollback_tag;

    modport master (
        output stall, push, push_addr, pop, ckpt_save, rollback, rollback_tag,
        input  top_addr, top_valid, count, ckpt_tag
    );

    modport slave (
        input  stall, push, push_addr, pop, ckpt_save, rollback, rollback_tag,
        output top_addr, top_valid, count, ckpt_tag
    );
endinterface

// File: rtl/ras_speculative.sv
// Circular return-address stack with tagged checkpoints that restore tos, count and the top entry.
// Latency: outputs reflect an update one edge later; stall freezes push/pop/save, rollback still acts.
module ras_speculative #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int NCKPT = 4
) (
    input  logic              clk,
    input  logic              rst,
    ras_speculative_if.slave  ras
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(NCKPT);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PW-1:0]    tos;
        logic [CW-1:0]    cnt;
        logic [WIDTH-1:0] top;
    } ckpt_t;

    logic [WIDTH-1:0] mem [DEPTH];
    ckpt_t            slot [NCKPT];
    logic [PW-1:0]    tos;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    tag;

    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             do_repl;
    logic [PW-1:0]    tos_inc;
    logic [PW-1:0]    tos_dec;
    ckpt_t            rb_slot;

    always_comb begin
        empty   = (cnt == '0);
        full    = (cnt == CW'(DEPTH));
        tos_inc = tos + PW'(1);
        tos_dec = tos - PW'(1);
        // push+pop on a live stack is a return followed by a call: replace the top in place
        do_repl = ras.push && ras.pop && !empty;
        do_push = ras.push && !do_repl;
        do_pop  = ras.pop && !ras.push && !empty;
        rb_slot = slot[ras.rollback_tag];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            for (int j = 0; j < NCKPT; j++) slot[j] <= '0;
            tos <= '0;
            cnt <= '0;
            tag <= '0;
        end else if (ras.rollback) begin
            tos              <= rb_slot.tos;
            cnt              <= rb_slot.cnt;
            mem[rb_slot.tos] <= rb_slot.top;
            tag              <= ras.rollback_tag + TW'(1);
        end else if (!ras.stall) begin
            if (ras.ckpt_save) begin
                slot[tag] <= '{tos: tos, cnt: cnt, top: mem[tos]};
                tag       <= tag + TW'(1);
            end
            if (do_repl) begin
                mem[tos] <= ras.push_addr;
            end else if (do_push) begin
                // at full depth the ring silently overwrites the oldest entry
                tos          <= tos_inc;
                mem[tos_inc] <= ras.push_addr;
                if (!full) cnt <= cnt + CW'(1);
            end else if (do_pop) begin
                tos <= tos_dec;
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign ras.top_addr  = mem[tos];
    assign ras.top_valid = !empty;
    assign ras.count     = cnt;
    assign ras.ckpt_tag  = tag;
endmodule

// File: tb/tb_ras_speculative.sv
// Bench for ras_speculative: directed vector table, async reset check, randomized run against a ring model.
module tb_ras_speculative;
    localparam int D = 4;
    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ras_speculative_if #(.DEPTH(D), .WIDTH(W), .NCKPT(N)) ras_if ();

    ras_speculative #(.DEPTH(D), .WIDTH(W), .NCKPT(N)) dut (
        .clk (clk),
        .rst (rst),
        .ras (ras_if.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference: physical ring of D entries, integer pointer arithmetic
    logic [W-1:0] m_mem [D];
    int           m_tos, m_cnt, m_tag;
    int           s_tos [N];
    int           s_cnt [N];
    logic [W-1:0] s_top [N];

    typedef struct {
        bit        stall, push, pop, save, rb;
        int        rbtag;
        logic [W-1:0] addr;
        logic [W-1:0] e_top;
        bit        e_valid;
        int        e_cnt, e_tag;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        for (int i = 0; i < N; i++) begin
            s_tos[i] = 0; s_cnt[i] = 0; s_top[i] = '0;
        end
        m_tos = 0; m_cnt = 0; m_tag = 0;
    endtask

    task automatic model_step(input bit stall, input bit push, input logic [W-1:0] addr,
                              input bit pop, input bit save, input bit rb, input int rbtag);
        if (rb) begin
            m_tos        = s_tos[rbtag];
            m_cnt        = s_cnt[rbtag];
            m_mem[m_tos] = s_top[rbtag];
            m_tag        = (rbtag + 1) % N;
        end else if (!stall) begin
            if (save) begin
                s_tos[m_tag] = m_tos;
                s_cnt[m_tag] = m_cnt;
                s_top[m_tag] = m_mem[m_tos];
                m_tag        = (m_tag + 1) % N;
            end
            if (push && pop && m_cnt > 0) begin
                m_mem[m_tos] = addr;
            end else if (push) begin
                m_tos        = (m_tos + 1) % D;
                m_mem[m_tos] = addr;
                m_cnt        = (m_cnt < D) ? m_cnt + 1 : D;
            end else if (pop && m_cnt > 0) begin
                m_tos = (m_tos + D - 1) % D;
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic drive(input bit stall, input bit push, input logic [W-1:0] addr,
                         input bit pop, input bit save, input bit rb, input int rbtag);
        ras_if.stall        = stall;
        ras_if.push         = push;
        ras_if.push_addr    = addr;
        ras_if.pop          = pop;
        ras_if.ckpt_save    = save;
        ras_if.rollback     = rb;
        ras_if.rollback_tag = rbtag[1:0];
    endtask

    // one clock with the given controls; model advances at the same edge
    task automatic step(input bit stall, input bit push, input logic [W-1:0] addr,
                        input bit pop, input bit save, input bit rb, input int rbtag);
        drive(stall, push, addr, pop, save, rb, rbtag);
        @(posedge clk);
        model_step(stall, push, addr, pop, save, rb, rbtag);
        #1;
        drive(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".top_addr"},  ras_if.top_addr,  m_mem[m_tos]);
        chk({tag, ".top_valid"}, 32'(ras_if.top_valid), 32'(m_cnt != 0));
        chk({tag, ".count"},     32'(ras_if.count),  32'(m_cnt));
        chk({tag, ".ckpt_tag"},  32'(ras_if.ckpt_tag), 32'(m_tag));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".top_addr"},  ras_if.top_addr, '0);
        chk({tag, ".top_valid"}, 32'(ras_if.top_valid), '0);
        chk({tag, ".count"},     32'(ras_if.count), '0);
        chk({tag, ".ckpt_tag"},  32'(ras_if.ckpt_tag), '0);
    endtask

    function automatic vec_t v(bit stall, bit push, logic [W-1:0] addr, bit pop, bit save,
                               bit rb, int rbtag, logic [W-1:0] e_top, bit e_valid,
                               int e_cnt, int e_tag);
        vec_t r;
        r.stall = stall; r.push = push; r.addr = addr; r.pop = pop; r.save = save;
        r.rb = rb; r.rbtag = rbtag; r.e_top = e_top; r.e_valid = e_valid;
        r.e_cnt = e_cnt; r.e_tag = e_tag;
        return r;
    endfunction

    task automatic random_run(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            bit st, pu, po, sv, rb;
            st = ($urandom_range(0, 99) < 15);
            pu = ($urandom_range(0, 99) < 45);
            po = ($urandom_range(0, 99) < 45);
            sv = ($urandom_range(0, 99) < 20);
            rb = ($urandom_range(0, 99) < 8);
            step(st, pu, $urandom, po, sv, rb, int'($urandom_range(0, N - 1)));
            chk_model(tag);
        end
    endtask

    initial begin
        drive(0, 0, '0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        //        st pu addr      po sv rb t   top       v  cnt tag
        vecs.push_back(v(0, 1, 32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 0));
        vecs.push_back(v(0, 1, 32'h200, 0, 0, 0, 0, 32'h200, 1, 2, 0));
        vecs.push_back(v(0, 1, 32'h300, 0, 0, 0, 0, 32'h300, 1, 3, 0));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'h200, 1, 2, 0));
        vecs.push_back(v(0, 1, 32'h900, 1, 0, 0, 0, 32'h900, 1, 2, 0));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'h100, 1, 1, 0));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 0, 0));
        // underflow
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 0, 0));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 0, 0));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 0, 0));
        vecs.push_back(v(0, 1, 32'h40,  0, 0, 0, 0, 32'h40,  1, 1, 0));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   0, 0, 0));
        // overflow wrap then drain
        vecs.push_back(v(0, 1, 32'hA0,  0, 0, 0, 0, 32'hA0,  1, 1, 0));
        vecs.push_back(v(0, 1, 32'hB0,  0, 0, 0, 0, 32'hB0,  1, 2, 0));
        vecs.push_back(v(0, 1, 32'hC0,  0, 0, 0, 0, 32'hC0,  1, 3, 0));
        vecs.push_back(v(0, 1, 32'hD0,  0, 0, 0, 0, 32'hD0,  1, 4, 0));
        vecs.push_back(v(0, 1, 32'hE0,  0, 0, 0, 0, 32'hE0,  1, 4, 0));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'hD0,  1, 3, 0));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'hC0,  1, 2, 0));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'hB0,  1, 1, 0));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'hE0,  0, 0, 0));
        // checkpoint, corrupt top, roll back
        vecs.push_back(v(0, 1, 32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 0));
        vecs.push_back(v(0, 1, 32'h200, 0, 0, 0, 0, 32'h200, 1, 2, 0));
        vecs.push_back(v(0, 0, 32'h0,   0, 1, 0, 0, 32'h200, 1, 2, 1));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'h100, 1, 1, 1));
        vecs.push_back(v(0, 1, 32'h700, 0, 0, 0, 0, 32'h700, 1, 2, 1));
        vecs.push_back(v(0, 0, 32'h0,   0, 0, 1, 0, 32'h200, 1, 2, 1));
        vecs.push_back(v(0, 0, 32'h0,   1, 0, 0, 0, 32'h100, 1, 1, 1));
        // save with same-cycle push, then rollback beats push under stall
        vecs.push_back(v(0, 1, 32'h300, 0, 1, 0, 0, 32'h300, 1, 2, 2));
        vecs.push_back(v(1, 1, 32'h555, 0, 0, 1, 1, 32'h100, 1, 1, 2));
        vecs.push_back(v(1, 1, 32'h777, 0, 0, 0, 0, 32'h100, 1, 1, 2));
        vecs.push_back(v(1, 0, 32'h0,   1, 1, 0, 0, 32'h100, 1, 1, 2));

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            step(vecs[i].stall, vecs[i].push, vecs[i].addr, vecs[i].pop,
                 vecs[i].save, vecs[i].rb, vecs[i].rbtag);
            chk({nm, ".top_addr"},  ras_if.top_addr, vecs[i].e_top);
            chk({nm, ".top_valid"}, 32'(ras_if.top_valid), 32'(vecs[i].e_valid));
            chk({nm, ".count"},     32'(ras_if.count), 32'(vecs[i].e_cnt));
            chk({nm, ".ckpt_tag"},  32'(ras_if.ckpt_tag), 32'(vecs[i].e_tag));
        end

        random_run(2000, "rand");

        // async reset between edges clears outputs before any clock arrives
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        model_reset();
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("post_rst");

        // cleared slots: rolling back to any tag yields an empty stack
        step(0, 1, 32'h1234, 0, 0, 0, 0);
        step(0, 0, '0, 0, 0, 1, 2);
        chk("rb_cleared.count", 32'(ras_if.count), '0);
        chk("rb_cleared.ckpt_tag", 32'(ras_if.ckpt_tag), 32'd3);
        chk_model("rb_cleared");

        random_run(1000, "rand2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
